// File: rtl/home_sensor_frontend.sv
// home_sensor_frontend: minute-of-day clock, day/night window, computer
// inactivity timer and PIR debounce feeding the home automation controller.
// Optional build macro: PRESENCE_KEEPALIVE_EN (presence holds the
// inactivity timer in ACTIVE while presence_detected is high).
module home_sensor_frontend #(
    parameter int unsigned TICKS_PER_MIN   = 6000000,
    parameter int unsigned INACTIVE_MIN    = 15,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned DAY_START_MIN   = 420,
    parameter int unsigned NIGHT_START_MIN = 1320
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pir_raw,
    input  logic        activity_pulse,
    input  logic        set_time_valid,
    input  logic [10:0] set_time_min,
    output logic [10:0] minute_of_day,
    output logic        time_of_day,
    output logic        computer_inactive,
    output logic        presence_detected,
    output logic        status_changed
);

    localparam int unsigned PW  = $clog2(TICKS_PER_MIN);
    localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [PW-1:0]  PRESC_MAX  = PW'(TICKS_PER_MIN - 1);
    localparam logic [10:0]    MIN_MAX    = 11'd1439;
    localparam logic [10:0]    DAY_MIN    = 11'(DAY_START_MIN);
    localparam logic [10:0]    NIGHT_MIN  = 11'(NIGHT_START_MIN);
    localparam logic [9:0]     IDLE_LIMIT = 10'(INACTIVE_MIN);
    localparam logic [DBW-1:0] DB_LIMIT   = DBW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        INA_ACTIVE   = 2'd0,
        INA_COUNTING = 2'd1,
        INA_INACTIVE = 2'd2
    } ina_state_e;

    typedef enum logic [1:0] {
        PRS_ABSENT      = 2'd0,
        PRS_CONFIRM_ON  = 2'd1,
        PRS_PRESENT     = 2'd2,
        PRS_CONFIRM_OFF = 2'd3
    } prs_state_e;

    logic [PW-1:0]  presc_q, presc_d;
    logic [10:0]    minute_q, minute_d;
    logic           tod_q, tod_d;
    ina_state_e     ina_state_q, ina_state_d;
    logic [9:0]     idle_cnt_q, idle_cnt_d;
    logic           inactive_q, inactive_d;
    prs_state_e     prs_state_q, prs_state_d;
    logic [DBW-1:0] prs_cnt_q, prs_cnt_d;
    logic           presence_q, presence_d;
    logic           status_changed_q, status_changed_d;

    logic           minute_tick_c;
    logic           load_ok_c;
    logic           keepalive_c;
    logic           activity_c;
    logic [DBW-1:0] prs_cnt_inc_c;

`ifdef PRESENCE_KEEPALIVE_EN
    assign keepalive_c = presence_q;
`else
    assign keepalive_c = 1'b0;
`endif

    assign activity_c    = activity_pulse | keepalive_c;
    assign minute_tick_c = (presc_q == PRESC_MAX);
    assign load_ok_c     = set_time_valid && (set_time_min <= MIN_MAX);
    assign prs_cnt_inc_c = prs_cnt_q + DBW'(1);

    // Prescaler, minute clock and day/night window from the next minute value
    always_comb begin
        presc_d  = presc_q + PW'(1);
        minute_d = minute_q;
        if (load_ok_c) begin
            presc_d  = '0;
            minute_d = set_time_min;
        end else if (minute_tick_c) begin
            presc_d  = '0;
            minute_d = (minute_q == MIN_MAX) ? 11'd0 : minute_q + 11'd1;
        end
        tod_d = (minute_d >= DAY_MIN) && (minute_d < NIGHT_MIN);
    end

    // Inactivity timer: counts minute ticks since the cycle after activity
    always_comb begin
        ina_state_d = ina_state_q;
        idle_cnt_d  = idle_cnt_q;
        if (activity_c) begin
            ina_state_d = INA_ACTIVE;
            idle_cnt_d  = '0;
        end else begin
            case (ina_state_q)
                INA_ACTIVE: begin
                    ina_state_d = INA_COUNTING;
                end
                INA_COUNTING: begin
                    if (minute_tick_c) begin
                        idle_cnt_d = idle_cnt_q + 10'd1;
                        if (idle_cnt_q + 10'd1 == IDLE_LIMIT) begin
                            ina_state_d = INA_INACTIVE;
                        end
                    end
                end
                INA_INACTIVE: begin
                    ina_state_d = INA_INACTIVE;
                end
                default: begin
                    ina_state_d = INA_ACTIVE;
                    idle_cnt_d  = '0;
                end
            endcase
        end
        inactive_d = (ina_state_d == INA_INACTIVE);
    end

    // PIR debounce: a level must hold DEBOUNCE_CYCLES samples to flip presence
    always_comb begin
        prs_state_d = prs_state_q;
        prs_cnt_d   = prs_cnt_q;
        case (prs_state_q)
            PRS_ABSENT, PRS_CONFIRM_ON: begin
                if (!pir_raw) begin
                    prs_state_d = PRS_ABSENT;
                    prs_cnt_d   = '0;
                end else if (prs_cnt_inc_c == DB_LIMIT) begin
                    prs_state_d = PRS_PRESENT;
                    prs_cnt_d   = '0;
                end else begin
                    prs_state_d = PRS_CONFIRM_ON;
                    prs_cnt_d   = prs_cnt_inc_c;
                end
            end
            PRS_PRESENT, PRS_CONFIRM_OFF: begin
                if (pir_raw) begin
                    prs_state_d = PRS_PRESENT;
                    prs_cnt_d   = '0;
                end else if (prs_cnt_inc_c == DB_LIMIT) begin
                    prs_state_d = PRS_ABSENT;
                    prs_cnt_d   = '0;
                end else begin
                    prs_state_d = PRS_CONFIRM_OFF;
                    prs_cnt_d   = prs_cnt_inc_c;
                end
            end
            default: begin
                prs_state_d = PRS_ABSENT;
                prs_cnt_d   = '0;
            end
        endcase
        presence_d = (prs_state_d == PRS_PRESENT) || (prs_state_d == PRS_CONFIRM_OFF);
    end

    // Change pulse coincides with the cycle the new status bit is visible
    always_comb begin
        status_changed_d = (tod_d ^ tod_q) | (inactive_d ^ inactive_q) | (presence_d ^ presence_q);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q          <= '0;
            minute_q         <= '0;
            tod_q            <= 1'b0;
            ina_state_q      <= INA_ACTIVE;
            idle_cnt_q       <= '0;
            inactive_q       <= 1'b0;
            prs_state_q      <= PRS_ABSENT;
            prs_cnt_q        <= '0;
            presence_q       <= 1'b0;
            status_changed_q <= 1'b0;
        end else begin
            presc_q          <= presc_d;
            minute_q         <= minute_d;
            tod_q            <= tod_d;
            ina_state_q      <= ina_state_d;
            idle_cnt_q       <= idle_cnt_d;
            inactive_q       <= inactive_d;
            prs_state_q      <= prs_state_d;
            prs_cnt_q        <= prs_cnt_d;
            presence_q       <= presence_d;
            status_changed_q <= status_changed_d;
        end
    end

    assign minute_of_day     = minute_q;
    assign time_of_day       = tod_q;
    assign computer_inactive = inactive_q;
    assign presence_detected = presence_q;
    assign status_changed    = status_changed_q;

endmodule

// File: tb/tb_home_sensor_frontend.sv
// Bench for home_sensor_frontend: directed stimulus, a behavioural model
// compared every cycle, and hand-computed spot checks.
module tb_home_sensor_frontend;

    localparam int unsigned T_MIN  = 4;
    localparam int unsigned I_MIN  = 3;
    localparam int unsigned DB     = 3;
    localparam int unsigned DAY_S  = 420;
    localparam int unsigned NIGHT_S = 1320;
`ifdef PRESENCE_KEEPALIVE_EN
    localparam bit KEEP = 1'b1;
`else
    localparam bit KEEP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pir_raw;
    logic        activity_pulse;
    logic        set_time_valid;
    logic [10:0] set_time_min;
    logic [10:0] minute_of_day;
    logic        time_of_day;
    logic        computer_inactive;
    logic        presence_detected;
    logic        status_changed;

    int n_cmp = 0;
    int n_bad = 0;

    home_sensor_frontend #(
        .TICKS_PER_MIN  (T_MIN),
        .INACTIVE_MIN   (I_MIN),
        .DEBOUNCE_CYCLES(DB),
        .DAY_START_MIN  (DAY_S),
        .NIGHT_START_MIN(NIGHT_S)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pir_raw          (pir_raw),
        .activity_pulse   (activity_pulse),
        .set_time_valid   (set_time_valid),
        .set_time_min     (set_time_min),
        .minute_of_day    (minute_of_day),
        .time_of_day      (time_of_day),
        .computer_inactive(computer_inactive),
        .presence_detected(presence_detected),
        .status_changed   (status_changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: cycles since last time base, ticks since activity,
    // and run length of the current PIR level.
    int unsigned m_cyc, m_min, m_idle, m_run_len;
    bit          m_fresh, m_run_val, m_tod, m_inact, m_pres, m_status, started;

    initial started = 1'b0;

    always @(posedge clk) begin
        bit tick, keep, o_tod, o_inact, o_pres;
        if (rst) begin
            m_cyc = 0; m_min = 0; m_idle = 0; m_fresh = 1'b1;
            m_run_val = 1'b0; m_run_len = 0;
            m_tod = 1'b0; m_inact = 1'b0; m_pres = 1'b0; m_status = 1'b0;
            started = 1'b1;
        end else if (started) begin
            tick    = (m_cyc % T_MIN) == T_MIN - 1;
            keep    = KEEP && m_pres;
            o_tod   = m_tod; o_inact = m_inact; o_pres = m_pres;
            if (set_time_valid && int'(set_time_min) <= 1439) begin
                m_min = set_time_min;
                m_cyc = 0;
            end else begin
                if (tick) m_min = (m_min + 1) % 1440;
                m_cyc++;
            end
            m_tod = (m_min >= DAY_S) && (m_min < NIGHT_S);
            if (activity_pulse || keep) begin
                m_idle = 0; m_fresh = 1'b1;
            end else if (m_fresh) begin
                m_fresh = 1'b0;
            end else if (tick && m_idle < I_MIN) begin
                m_idle++;
            end
            m_inact = (m_idle >= I_MIN);
            if (pir_raw == m_run_val) begin
                if (m_run_len < 1000) m_run_len++;
            end else begin
                m_run_val = pir_raw; m_run_len = 1;
            end
            if (m_pres != m_run_val && m_run_len >= DB) m_pres = m_run_val;
            m_status = (o_tod != m_tod) || (o_inact != m_inact) || (o_pres != m_pres);
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            check("model_minute", int'(minute_of_day), int'(m_min));
            check("model_tod", int'(time_of_day), int'(m_tod));
            check("model_inactive", int'(computer_inactive), int'(m_inact));
            check("model_presence", int'(presence_detected), int'(m_pres));
            check("model_status", int'(status_changed), int'(m_status));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; pir_raw = 1'b0; activity_pulse = 1'b0;
        set_time_valid = 1'b0; set_time_min = 11'd0;
        step(2);
        rst = 1'b0;

        // Free-running clock from reset
        step(8);
        check("t1_minute", int'(minute_of_day), 2);
        check("t1_tod", int'(time_of_day), 0);
        check("t1_inactive", int'(computer_inactive), 0);
        check("t1_presence", int'(presence_detected), 0);
        check("t1_status", int'(status_changed), 0);

        // Inactivity after the third counted tick
        step(3);
        check("t3_inactive_before", int'(computer_inactive), 0);
        step(1);
        check("t3_inactive", int'(computer_inactive), 1);
        check("t3_status", int'(status_changed), 1);
        step(1);
        check("t3_status_drop", int'(status_changed), 0);
        step(2);
        activity_pulse = 1'b1;
        step(1);
        activity_pulse = 1'b0;
        check("t3_act_on_tick", int'(computer_inactive), 0);
        check("t3_act_minute", int'(minute_of_day), 4);
        check("t3_act_status", int'(status_changed), 1);

        // Time loads: wrap, day boundary, out-of-range ignored
        set_time_valid = 1'b1; set_time_min = 11'd1439;
        step(1);
        set_time_valid = 1'b0;
        check("t2_load1439", int'(minute_of_day), 1439);
        step(4);
        check("t2_wrap", int'(minute_of_day), 0);
        set_time_valid = 1'b1; set_time_min = 11'd419;
        step(1);
        set_time_valid = 1'b0;
        check("t2_load419", int'(minute_of_day), 419);
        step(3);
        check("t2_night", int'(time_of_day), 0);
        step(1);
        check("t2_minute420", int'(minute_of_day), 420);
        check("t2_day", int'(time_of_day), 1);
        check("t2_status", int'(status_changed), 1);
        step(1);
        check("t2_status_drop", int'(status_changed), 0);
        set_time_valid = 1'b1; set_time_min = 11'd1500;
        step(1);
        set_time_valid = 1'b0;
        check("t2_ignore_load", int'(minute_of_day), 420);
        step(2);
        check("t2_continue", int'(minute_of_day), 421);

        // PIR debounce: short glitch rejected, stable level accepted
        pir_raw = 1'b1;
        step(2);
        pir_raw = 1'b0;
        step(1);
        check("t4_glitch", int'(presence_detected), 0);
        step(2);
        pir_raw = 1'b1;
        step(2);
        check("t4_confirm", int'(presence_detected), 0);
        step(1);
        check("t4_present", int'(presence_detected), 1);
        check("t4_status", int'(status_changed), 1);
        step(20);
        check("t6_presence_held", int'(presence_detected), 1);
        check("t6_keepalive", int'(computer_inactive), KEEP ? 0 : 1);
        pir_raw = 1'b0;
        step(2);
        check("t4_off_confirm", int'(presence_detected), 1);
        step(1);
        check("t4_absent", int'(presence_detected), 0);
        pir_raw = 1'b1;
        step(3);
        check("t5_pre_presence", int'(presence_detected), 1);
        check("t5_pre_inactive", int'(computer_inactive), KEEP ? 0 : 1);

        // Reset mid-operation
        rst = 1'b1;
        step(1);
        check("t5_minute", int'(minute_of_day), 0);
        check("t5_tod", int'(time_of_day), 0);
        check("t5_inactive", int'(computer_inactive), 0);
        check("t5_presence", int'(presence_detected), 0);
        check("t5_status", int'(status_changed), 0);
        rst = 1'b0; pir_raw = 1'b0;
        step(1);
        check("t5_release_status", int'(status_changed), 0);
        check("t5_release_minute", int'(minute_of_day), 0);

        // Night boundary
        step(2);
        set_time_valid = 1'b1; set_time_min = 11'd1319;
        step(1);
        set_time_valid = 1'b0;
        check("nb_load", int'(minute_of_day), 1319);
        check("nb_day", int'(time_of_day), 1);
        step(4);
        check("nb_minute", int'(minute_of_day), 1320);
        check("nb_night", int'(time_of_day), 0);
        check("nb_status", int'(status_changed), 1);

        // Mixed pattern exercising the model over a longer stretch
        for (int i = 0; i < 160; i++) begin
            pir_raw        = ((i % 11) < 6);
            activity_pulse = ((i % 41) == 7);
            set_time_valid = (i == 90);
            set_time_min   = 11'd418;
            step(1);
        end
        pir_raw = 1'b0; activity_pulse = 1'b0; set_time_valid = 1'b0;
        step(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
